// File: rtl/intersection_pkg.sv
// Shared phase indices, interval state encoding, default timing and next-phase helper
// for the intersection phase scheduler.
package intersection_pkg;

  localparam logic [1:0] PhStraight     = 2'd0;
  localparam logic [1:0] PhStraightTurn = 2'd1;
  localparam logic [1:0] PhCross        = 2'd2;
  localparam logic [1:0] PhCrossTurn    = 2'd3;

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StAllRed = 2'd2
  } state_e;

  localparam int unsigned DefClkPerSec     = 1000;
  localparam int unsigned DefStraightGreenS = 120;
  localparam int unsigned DefTurnGreenS    = 60;
  localparam int unsigned DefShortenS      = 30;
  localparam int unsigned DefYellowS       = 4;
  localparam int unsigned DefAllRedS       = 2;

  // First phase after p (cyclically) with a pending request, else p+1.
  function automatic logic [1:0] next_phase_skip(input logic [1:0] p, input logic [3:0] dem);
    logic [1:0] q;
    next_phase_skip = p + 2'd1;
    for (int k = 3; k >= 1; k--) begin
      q = p + 2'(k);
      if (dem[q]) next_phase_skip = q;
    end
  endfunction

endpackage

// File: rtl/second_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_PER_SEC cycles; tick is masked during reset.
module second_prescaler #(
  parameter int unsigned CLK_PER_SEC = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_SEC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntMax) && !reset;

endmodule

// File: rtl/phase_scheduler.sv
// Four-phase intersection scheduler: GREEN -> YELLOW -> ALL_RED per phase with demand latching
// and green shortening. Define PHASE_SCHEDULER_SKIP_EN to skip phases without pending demand.
module phase_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC      = DefClkPerSec,
  parameter int unsigned STRAIGHT_GREEN_S = DefStraightGreenS,
  parameter int unsigned TURN_GREEN_S     = DefTurnGreenS,
  parameter int unsigned SHORTEN_S        = DefShortenS,
  parameter int unsigned YELLOW_S         = DefYellowS,
  parameter int unsigned ALL_RED_S        = DefAllRedS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] car_sensor,
  input  logic [1:0] ped_button,
  output logic [1:0] phase,
  output logic [3:0] lane_green,
  output logic [3:0] lane_yellow,
  output logic [1:0] ped_walk,
  output logic [6:0] seconds_left,
  output logic [3:0] demand,
  output logic       sec_tick
);

  localparam logic [6:0] StraightGreen = 7'(STRAIGHT_GREEN_S);
  localparam logic [6:0] TurnGreen     = 7'(TURN_GREEN_S);
  localparam logic [6:0] ShortenSecs   = 7'(SHORTEN_S);
  localparam logic [6:0] YellowSecs    = 7'(YELLOW_S);
  localparam logic [6:0] AllRedSecs    = 7'(ALL_RED_S);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d, nxt_phase;
  logic [6:0] secs_q, secs_d;
  logic [3:0] dem_q, dem_d, dem_set, req, green_mask;
  logic [3:0] lane_green_q, lane_green_d, lane_yellow_q, lane_yellow_d;
  logic [1:0] ped_walk_q, ped_walk_d;

  second_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (sec_tick)
  );

`ifdef PHASE_SCHEDULER_SKIP_EN
  assign nxt_phase = next_phase_skip(phase_q, dem_q);
`else
  assign nxt_phase = phase_q + 2'd1;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    secs_d     = secs_q;
    req        = car_sensor | {1'b0, ped_button[1], 1'b0, ped_button[0]};
    // Requests for the phase currently showing green are dropped.
    green_mask = (state_q == StGreen) ? (4'(1) << phase_q) : 4'b0000;
    dem_set    = (dem_q | req) & ~green_mask;
    dem_d      = dem_set;

    if (sec_tick && (secs_q == 7'd0)) begin
      unique case (state_q)
        StGreen: begin
          state_d = StYellow;
          secs_d  = YellowSecs;
        end
        StYellow: begin
          state_d = StAllRed;
          secs_d  = AllRedSecs;
        end
        StAllRed: begin
          state_d = StGreen;
          phase_d = nxt_phase;
          secs_d  = nxt_phase[0] ? TurnGreen : StraightGreen;
          dem_d   = dem_set & ~(4'(1) << nxt_phase);
        end
        default: begin
          state_d = StGreen;
          phase_d = PhStraight;
          secs_d  = StraightGreen;
        end
      endcase
    end else if ((state_q == StGreen) && (secs_q > ShortenSecs) && (|dem_set)) begin
      secs_d = ShortenSecs;
    end else if (sec_tick) begin
      secs_d = secs_q - 7'd1;
    end

    lane_green_d  = (state_d == StGreen)  ? (4'(1) << phase_d) : 4'b0000;
    lane_yellow_d = (state_d == StYellow) ? (4'(1) << phase_d) : 4'b0000;
    ped_walk_d    = {(state_d == StGreen) && (phase_d == PhCross),
                     (state_d == StGreen) && (phase_d == PhStraight)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StGreen;
      phase_q       <= PhStraight;
      secs_q        <= StraightGreen;
      dem_q         <= 4'b0000;
      lane_green_q  <= 4'b0001;
      lane_yellow_q <= 4'b0000;
      ped_walk_q    <= 2'b01;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      secs_q        <= secs_d;
      dem_q         <= dem_d;
      lane_green_q  <= lane_green_d;
      lane_yellow_q <= lane_yellow_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

  assign phase        = phase_q;
  assign seconds_left = secs_q;
  assign demand       = dem_q;
  assign lane_green   = lane_green_q;
  assign lane_yellow  = lane_yellow_q;
  assign ped_walk     = ped_walk_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Randomized and directed bench for phase_scheduler against a behavioural interval model.
module tb_phase_scheduler;

  localparam int Cps = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] car_sensor = 4'b0000;
  logic [1:0] ped_button = 2'b00;
  logic [1:0] phase;
  logic [3:0] lane_green, lane_yellow, demand;
  logic [1:0] ped_walk;
  logic [6:0] seconds_left;
  logic       sec_tick;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: cycle counter, interval kind (0 green, 1 yellow, 2 all-red), seconds, demand.
  int       m_cnt, m_phase, m_st, m_secs;
  bit [3:0] m_dem;

  always #5 clk = ~clk;

  phase_scheduler #(
    .CLK_PER_SEC     (Cps),
    .STRAIGHT_GREEN_S(120),
    .TURN_GREEN_S    (60),
    .SHORTEN_S       (30),
    .YELLOW_S        (4),
    .ALL_RED_S       (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .car_sensor  (car_sensor),
    .ped_button  (ped_button),
    .phase       (phase),
    .lane_green  (lane_green),
    .lane_yellow (lane_yellow),
    .ped_walk    (ped_walk),
    .seconds_left(seconds_left),
    .demand      (demand),
    .sec_tick    (sec_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int green_len(input int p);
    return (p % 2 == 0) ? 120 : 60;
  endfunction

  function automatic int pick_next(input int p, input bit [3:0] dem);
`ifdef PHASE_SCHEDULER_SKIP_EN
    for (int k = 1; k <= 3; k++) if (dem[(p + k) % 4]) return (p + k) % 4;
`endif
    return (p + 1) % 4;
  endfunction

  task automatic model_step();
    bit       tick;
    bit [3:0] rq, nd;
    if (reset) begin
      m_cnt = 0; m_phase = 0; m_st = 0; m_secs = 120; m_dem = '0;
      return;
    end
    tick  = (m_cnt == Cps - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    rq    = car_sensor;
    rq[0] = rq[0] | ped_button[0];
    rq[2] = rq[2] | ped_button[1];
    for (int q = 0; q < 4; q++) nd[q] = (m_dem[q] | rq[q]) && !(m_st == 0 && q == m_phase);
    if (tick && m_secs == 0) begin
      if (m_st == 0) begin
        m_st = 1; m_secs = 4;
      end else if (m_st == 1) begin
        m_st = 2; m_secs = 2;
      end else begin
        m_phase = pick_next(m_phase, m_dem);
        m_st = 0; m_secs = green_len(m_phase);
        nd[m_phase] = 1'b0;
      end
    end else if (m_st == 0 && m_secs > 30 && nd != 0) begin
      m_secs = 30;
    end else if (tick) begin
      m_secs = m_secs - 1;
    end
    m_dem = nd;
  endtask

  task automatic compare_all();
    check_eq("phase", phase, m_phase);
    check_eq("lane_green", lane_green, (m_st == 0) ? (1 << m_phase) : 0);
    check_eq("lane_yellow", lane_yellow, (m_st == 1) ? (1 << m_phase) : 0);
    check_eq("ped_walk", ped_walk, {m_st == 0 && m_phase == 2, m_st == 0 && m_phase == 0});
    check_eq("seconds_left", seconds_left, m_secs);
    check_eq("demand", demand, m_dem);
    check_eq("sec_tick", sec_tick, (m_cnt == Cps - 1) && !reset);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic int dut_state();
    if (lane_green != 0) return 0;
    if (lane_yellow != 0) return 1;
    return 2;
  endfunction

  initial begin
    int seq[$];
    int gticks, yticks, rticks, prev_st, budget;

    // Reset state and the undisturbed phase rotation with interval lengths.
    do_reset();
    check_eq("rst_phase", phase, 0);
    check_eq("rst_lane_green", lane_green, 4'b0001);
    check_eq("rst_lane_yellow", lane_yellow, 0);
    check_eq("rst_ped_walk", ped_walk, 2'b01);
    check_eq("rst_secs", seconds_left, 120);
    check_eq("rst_demand", demand, 0);
    check_eq("rst_tick", sec_tick, 0);
    seq.push_back(phase);
    gticks = 0; yticks = 0; rticks = 0; prev_st = 0; budget = 0;
    while (seq.size() < 5 && budget < 6000) begin
      if (seq.size() == 1 && sec_tick && seconds_left != 0) begin
        if (dut_state() == 0) gticks++;
        else if (dut_state() == 1) yticks++;
        else rticks++;
      end
      step();
      budget++;
      if (dut_state() == 0 && prev_st != 0) seq.push_back(phase);
      prev_st = dut_state();
    end
    check_eq("rotation_len", seq.size(), 5);
    for (int k = 0; k < seq.size(); k++) check_eq("rotation_phase", seq[k], k % 4);
    check_eq("green0_ticks", gticks, 120);
    check_eq("yellow0_ticks", yticks, 4);
    check_eq("allred0_ticks", rticks, 2);

    // Cross-street car shortens phase 0 green, then decides the next phase.
    do_reset();
    budget = 0;
    while (seconds_left != 100 && budget < 400) begin step(); budget++; end
    check_eq("reach_secs100", seconds_left, 100);
    car_sensor = 4'b0100;
    step();
    car_sensor = 4'b0000;
    check_eq("shorten_secs", seconds_left, 30);
    check_eq("shorten_dem2", demand[2], 1);
    budget = 0;
    while (!(lane_green != 0 && phase != 0) && budget < 1000) begin step(); budget++; end
    check_eq("next_green_seen", lane_green != 0 && phase != 0, 1);
`ifdef PHASE_SCHEDULER_SKIP_EN
    check_eq("next_green_phase", phase, 2);
`else
    check_eq("next_green_phase", phase, 1);
`endif

    // Own-phase pedestrian button during green is ignored.
    do_reset();
    ped_button = 2'b01;
    repeat (200) step();
    ped_button = 2'b00;
    check_eq("ped0_demand", demand, 0);
    check_eq("ped0_no_shorten", seconds_left > 30, 1);

    // Car on phase 1 exactly at its green entry leaves no demand behind.
    budget = 0;
    while (!(dut_state() == 2 && seconds_left == 0 && sec_tick) && budget < 2000) begin
      step(); budget++;
    end
    check_eq("reach_allred_exit", dut_state() == 2 && seconds_left == 0 && sec_tick, 1);
    car_sensor = 4'b0010;
    step();
    step();
    car_sensor = 4'b0000;
    step();
    check_eq("entry_phase1", phase, 1);
    check_eq("entry_dem1", demand[1], 0);

    // Reset in phase 3 yellow with requests pending.
    budget = 0;
    while (!(phase == 3 && lane_yellow != 0) && budget < 4000) begin step(); budget++; end
    check_eq("reach_p3_yellow", phase == 3 && lane_yellow != 0, 1);
    car_sensor = 4'b0011;
    step();
    do_reset();
    car_sensor = 4'b0000;
    check_eq("mid_rst_phase", phase, 0);
    check_eq("mid_rst_green", lane_green, 4'b0001);
    check_eq("mid_rst_secs", seconds_left, 120);
    check_eq("mid_rst_demand", demand, 0);

    // Random sensors, buttons and occasional reset, checked every cycle against the model.
    for (int i = 0; i < 15000; i++) begin
      for (int b = 0; b < 4; b++) car_sensor[b] = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 2; b++) ped_button[b] = ($urandom_range(0, 599) == 0);
      reset = ($urandom_range(0, 4999) == 0);
      step();
    end
    reset = 1'b0;
    car_sensor = 4'b0000;
    ped_button = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
